// File: rtl/tlb_lookup_if.sv
// Translator/TLB port bundle: lookup, write, read and INVTLB sweep channels.
// master: the requesting side (address translator / CSR unit).
// slave:  the TLB itself.
interface tlb_lookup_if #(
    parameter int unsigned TLBNUM = 16
);
    localparam int unsigned IDXW = $clog2(TLBNUM);
    localparam int unsigned EW   = 89;

    // lookup channel
    logic            s_req;
    logic            s_ready;
    logic [19:0]     s_vpn;
    logic [9:0]      s_asid;
    logic            s_valid;
    logic            s_hit;
    logic [IDXW-1:0] s_index;
    logic [19:0]     s_pfn;
    logic [1:0]      s_mat;
    logic [1:0]      s_plv;
    logic            s_d;
    logic            s_v;

    // write channel
    logic            w_en;
    logic [IDXW-1:0] w_index;
    logic [EW-1:0]   w_entry;

    // read channel
    logic            r_en;
    logic [IDXW-1:0] r_index;
    logic            r_valid;
    logic [EW-1:0]   r_entry;

    // invalidate channel
    logic            inv_req;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [19:0]     inv_vpn;
    logic            inv_busy;
    logic            inv_done;

    modport master (
        output s_req, s_vpn, s_asid, w_en, w_index, w_entry, r_en, r_index,
               inv_req, inv_op, inv_asid, inv_vpn,
        input  s_ready, s_valid, s_hit, s_index, s_pfn, s_mat, s_plv, s_d, s_v,
               r_valid, r_entry, inv_busy, inv_done
    );

    modport slave (
        input  s_req, s_vpn, s_asid, w_en, w_index, w_entry, r_en, r_index,
               inv_req, inv_op, inv_asid, inv_vpn,
        output s_ready, s_valid, s_hit, s_index, s_pfn, s_mat, s_plv, s_d, s_v,
               r_valid, r_entry, inv_busy, inv_done
    );
endinterface

// File: rtl/tlb_lookup.sv
// Fully-associative TLB: one-cycle registered lookup and read, write port,
// and an INVTLB sweep that visits one entry per cycle.
// Ports: clk, resetn (async active-low), bus (tlb_lookup_if.slave) carrying
// the lookup, write, read and invalidate channels.
module tlb_lookup #(
    parameter int unsigned TLBNUM = 16
) (
    input  logic          clk,
    input  logic          resetn,
    tlb_lookup_if.slave   bus
);
    localparam int unsigned IDXW = $clog2(TLBNUM);

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic        e;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    tlb_entry_t      entries [TLBNUM];
    state_t          state, state_d;
    logic [IDXW-1:0] idx;
    logic [4:0]      op_q;
    logic [9:0]      asid_q;
    logic [19:0]     vpn_q;
    logic            busy_d, done_d, sweep_clr_c;
    logic            hit_c;
    logic [IDXW-1:0] hit_idx_c;
    tlb_entry_t      hit_ent_c;
    logic            odd_c;
    logic [19:0]     pfn_c;

    // Page-size aware VA compare; only 4KB (12) and 2MB (21) pages can match.
    function automatic logic va_match(input tlb_entry_t ent, input logic [19:0] vpn);
        logic m;
        m = 1'b0;
        if (ent.ps == 6'd12)      m = (ent.vppn == vpn[19:1]);
        else if (ent.ps == 6'd21) m = (ent.vppn[18:9] == vpn[19:10]);
        return m;
    endfunction

    // Lookup match; descending scan so the lowest matching index wins.
    always_comb begin
        hit_c     = 1'b0;
        hit_idx_c = '0;
        for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
            if (entries[i].e && (entries[i].g || entries[i].asid == bus.s_asid)
                && va_match(entries[i], bus.s_vpn)) begin
                hit_c     = 1'b1;
                hit_idx_c = IDXW'(i);
            end
        end
    end

    // Odd/even page select and PFN assembly (2MB pages pass VA[20:12] through).
    always_comb begin
        hit_ent_c = entries[hit_idx_c];
        odd_c     = (hit_ent_c.ps == 6'd12) ? bus.s_vpn[0] : bus.s_vpn[9];
        pfn_c     = odd_c ? hit_ent_c.ppn1 : hit_ent_c.ppn0;
        if (hit_ent_c.ps != 6'd12) pfn_c = {pfn_c[19:9], bus.s_vpn[8:0]};
    end

    // Lookup response register; requests during a sweep are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.s_valid <= 1'b0;
            bus.s_hit   <= 1'b0;
            bus.s_index <= '0;
            bus.s_pfn   <= '0;
            bus.s_mat   <= '0;
            bus.s_plv   <= '0;
            bus.s_d     <= 1'b0;
            bus.s_v     <= 1'b0;
        end else begin
            bus.s_valid <= bus.s_req && (state != ST_SWEEP);
            if (bus.s_req && (state != ST_SWEEP)) begin
                bus.s_hit   <= hit_c;
                bus.s_index <= hit_c ? hit_idx_c : '0;
                bus.s_pfn   <= hit_c ? pfn_c : '0;
                bus.s_mat   <= hit_c ? (odd_c ? hit_ent_c.mat1 : hit_ent_c.mat0) : 2'b00;
                bus.s_plv   <= hit_c ? (odd_c ? hit_ent_c.plv1 : hit_ent_c.plv0) : 2'b00;
                bus.s_d     <= hit_c && (odd_c ? hit_ent_c.d1 : hit_ent_c.d0);
                bus.s_v     <= hit_c && (odd_c ? hit_ent_c.v1 : hit_ent_c.v0);
            end
        end
    end

    // Read response register; reads stay live during a sweep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.r_valid <= 1'b0;
            bus.r_entry <= '0;
        end else begin
            bus.r_valid <= bus.r_en;
            if (bus.r_en) bus.r_entry <= entries[bus.r_index];
        end
    end

    // Entry storage: writes blocked during a sweep, sweep clears e bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(TLBNUM); i++) entries[i] <= '0;
        end else begin
            if (bus.w_en && (state != ST_SWEEP)) entries[bus.w_index] <= bus.w_entry;
            if (sweep_clr_c) entries[idx].e <= 1'b0;
        end
    end

    // FSM state register plus registered status outputs and latched operands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            idx          <= '0;
            op_q         <= '0;
            asid_q       <= '0;
            vpn_q        <= '0;
            bus.inv_busy <= 1'b0;
            bus.inv_done <= 1'b0;
            bus.s_ready  <= 1'b1;
        end else begin
            state        <= state_d;
            bus.inv_busy <= busy_d;
            bus.inv_done <= done_d;
            bus.s_ready  <= !busy_d;
            idx          <= (state == ST_SWEEP) ? idx + 1'b1 : '0;
            if (bus.inv_req && (state != ST_SWEEP)) begin
                op_q   <= bus.inv_op;
                asid_q <= bus.inv_asid;
                vpn_q  <= bus.inv_vpn;
            end
        end
    end

    // Next-state: an illegal op skips the sweep and completes immediately.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (bus.inv_req) state_d = (bus.inv_op <= 5'd6) ? ST_SWEEP : ST_DONE;
            end
            ST_SWEEP: if (idx == IDXW'(TLBNUM - 1)) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: status flags follow the next state; per-entry invalidate predicate.
    always_comb begin
        busy_d      = (state_d == ST_SWEEP);
        done_d      = (state_d == ST_DONE);
        sweep_clr_c = 1'b0;
        if (state == ST_SWEEP) begin
            case (op_q)
                5'd0, 5'd1: sweep_clr_c = 1'b1;
                5'd2:       sweep_clr_c = entries[idx].g;
                5'd3:       sweep_clr_c = !entries[idx].g;
                5'd4:       sweep_clr_c = !entries[idx].g && entries[idx].asid == asid_q;
                5'd5:       sweep_clr_c = !entries[idx].g && entries[idx].asid == asid_q
                                          && va_match(entries[idx], vpn_q);
                5'd6:       sweep_clr_c = (entries[idx].g || entries[idx].asid == asid_q)
                                          && va_match(entries[idx], vpn_q);
                default:    sweep_clr_c = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_lookup.sv
// Directed bench for tlb_lookup: lookups, page sizes, priority, read-back,
// INVTLB sweeps, illegal op and reset during a sweep.
module tb_tlb_lookup;
    localparam int unsigned TLBNUM = 16;

    logic clk;
    logic resetn;
    int   total;
    int   bad;
    int   busy_cycles;
    int   guard;
    logic done_seen;

    tlb_lookup_if #(.TLBNUM(TLBNUM)) bus ();

    tlb_lookup #(.TLBNUM(TLBNUM)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [88:0] mk(input logic [18:0] vppn, input logic [5:0] ps,
                                       input logic g, input logic [9:0] asid,
                                       input logic [19:0] ppn0, input logic [1:0] mat0,
                                       input logic v0, input logic [19:0] ppn1,
                                       input logic [1:0] mat1, input logic v1);
        return {vppn, ps, g, asid, 1'b1, ppn0, 2'b00, mat0, 1'b0, v0,
                ppn1, 2'b00, mat1, 1'b0, v1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [19:0] vpn, input logic [9:0] asid);
        bus.s_req  = 1'b1;
        bus.s_vpn  = vpn;
        bus.s_asid = asid;
        tick();
        bus.s_req  = 1'b0;
    endtask

    task automatic write(input logic [3:0] index, input logic [88:0] ent);
        bus.w_en    = 1'b1;
        bus.w_index = index;
        bus.w_entry = ent;
        tick();
        bus.w_en    = 1'b0;
    endtask

    task automatic expect_hit(input string tag, input logic [3:0] index, input logic [19:0] pfn);
        chk({tag, "_valid"}, 89'(bus.s_valid), 89'(1));
        chk({tag, "_hit"},   89'(bus.s_hit),   89'(1));
        chk({tag, "_index"}, 89'(bus.s_index), 89'(index));
        chk({tag, "_pfn"},   89'(bus.s_pfn),   89'(pfn));
    endtask

    task automatic expect_miss(input string tag);
        chk({tag, "_valid"}, 89'(bus.s_valid), 89'(1));
        chk({tag, "_hit"},   89'(bus.s_hit),   89'(0));
        chk({tag, "_pfn"},   89'(bus.s_pfn),   89'(0));
    endtask

    task automatic run_inv(input logic [4:0] op, input logic [9:0] asid, input logic [19:0] vpn);
        bus.inv_req  = 1'b1;
        bus.inv_op   = op;
        bus.inv_asid = asid;
        bus.inv_vpn  = vpn;
        tick();
        bus.inv_req  = 1'b0;
        guard = 0;
        while (!bus.inv_done && guard < 40) begin
            tick();
            guard++;
        end
        chk("inv_done_seen", 89'(bus.inv_done), 89'(1));
        tick();
    endtask

    logic [88:0] e3;

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        bus.s_req = 1'b0; bus.s_vpn = '0; bus.s_asid = '0;
        bus.w_en = 1'b0; bus.w_index = '0; bus.w_entry = '0;
        bus.r_en = 1'b0; bus.r_index = '0;
        bus.inv_req = 1'b0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vpn = '0;
        e3 = mk(19'h091A2, 6'd12, 1'b0, 10'd5, 20'h0, 2'd0, 1'b0, 20'hABCDE, 2'd1, 1'b1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready",  89'(bus.s_ready),  89'(1));
        chk("rst_s_valid",  89'(bus.s_valid),  89'(0));
        chk("rst_inv_busy", 89'(bus.inv_busy), 89'(0));
        chk("rst_inv_done", 89'(bus.inv_done), 89'(0));
        chk("rst_r_valid",  89'(bus.r_valid),  89'(0));
        resetn = 1'b1;
        tick();

        // empty TLB misses; s_valid is a single pulse
        lookup(20'h12345, 10'd0);
        expect_miss("empty");
        tick();
        chk("valid_pulse", 89'(bus.s_valid), 89'(0));

        // 4KB entry, odd page
        write(4'd3, e3);
        lookup(20'h12345, 10'd5);
        expect_hit("p4k_odd", 4'd3, 20'hABCDE);
        chk("p4k_odd_mat", 89'(bus.s_mat), 89'(1));
        chk("p4k_odd_v",   89'(bus.s_v),   89'(1));
        lookup(20'h12344, 10'd5);
        expect_hit("p4k_even", 4'd3, 20'h00000);
        chk("p4k_even_v", 89'(bus.s_v), 89'(0));
        lookup(20'h12345, 10'd6);
        expect_miss("asid_miss");
        chk("asid_miss_idx", 89'(bus.s_index), 89'(0));

        // read back
        bus.r_en = 1'b1; bus.r_index = 4'd3;
        tick();
        bus.r_en = 1'b0;
        chk("read_valid", 89'(bus.r_valid), 89'(1));
        chk("read_entry", bus.r_entry, e3);

        // 2MB global entry
        write(4'd0, mk(19'h40000, 6'd21, 1'b1, 10'd0, 20'h00200, 2'd0, 1'b1, 20'h00400, 2'd0, 1'b1));
        lookup(20'h80055, 10'd9);
        expect_hit("p2m_even", 4'd0, 20'h00255);
        lookup(20'h80255, 10'd9);
        expect_hit("p2m_odd", 4'd0, 20'h00455);

        // duplicate VA: lowest index wins
        write(4'd7, mk(19'h11110, 6'd12, 1'b1, 10'd0, 20'h77777, 2'd0, 1'b1, 20'h0, 2'd0, 1'b0));
        write(4'd2, mk(19'h11110, 6'd12, 1'b1, 10'd0, 20'h22222, 2'd0, 1'b1, 20'h0, 2'd0, 1'b0));
        lookup(20'h22220, 10'd0);
        expect_hit("prio", 4'd2, 20'h22222);

        // same-cycle write and lookup sees old contents
        bus.w_en = 1'b1; bus.w_index = 4'd9;
        bus.w_entry = mk(19'h33330, 6'd12, 1'b0, 10'd5, 20'h99999, 2'd0, 1'b1, 20'h0, 2'd0, 1'b0);
        lookup(20'h66660, 10'd5);
        bus.w_en = 1'b0;
        expect_miss("wr_same_cycle");
        lookup(20'h66660, 10'd5);
        expect_hit("wr_next_cycle", 4'd9, 20'h99999);

        // non-global ASID 6 entry
        write(4'd5, mk(19'h05555, 6'd12, 1'b0, 10'd6, 20'h0, 2'd0, 1'b0, 20'h55555, 2'd0, 1'b1));
        lookup(20'h0AAAB, 10'd6);
        expect_hit("asid6", 4'd5, 20'h55555);

        // INVTLB op 4, asid 5 with operand change after acceptance
        bus.inv_req = 1'b1; bus.inv_op = 5'd4; bus.inv_asid = 10'd5;
        tick();
        bus.inv_req = 1'b0; bus.inv_asid = 10'd6;
        busy_cycles = 0;
        if (bus.inv_busy) busy_cycles++;
        chk("sweep_ready", 89'(bus.s_ready), 89'(0));
        bus.s_req = 1'b1; bus.s_vpn = 20'h80055; bus.s_asid = 10'd0;
        bus.w_en = 1'b1; bus.w_index = 4'd1;
        bus.w_entry = mk(19'h44440, 6'd12, 1'b1, 10'd0, 20'h00001, 2'd0, 1'b1, 20'h0, 2'd0, 1'b0);
        tick();
        bus.s_req = 1'b0; bus.w_en = 1'b0;
        chk("sweep_drop", 89'(bus.s_valid), 89'(0));
        if (bus.inv_busy) busy_cycles++;
        guard = 0;
        while (bus.inv_busy && guard < 40) begin
            tick();
            guard++;
            if (bus.inv_busy) busy_cycles++;
        end
        chk("busy_cycles", 89'(busy_cycles), 89'(TLBNUM));
        chk("op4_done",    89'(bus.inv_done), 89'(1));
        chk("op4_ready",   89'(bus.s_ready),  89'(1));
        tick();
        chk("op4_done_pulse", 89'(bus.inv_done), 89'(0));
        lookup(20'h12345, 10'd5);
        expect_miss("op4_cleared3");
        lookup(20'h66660, 10'd5);
        expect_miss("op4_cleared9");
        lookup(20'h0AAAB, 10'd6);
        expect_hit("op4_kept5", 4'd5, 20'h55555);
        lookup(20'h80055, 10'd5);
        expect_hit("op4_kept_g", 4'd0, 20'h00255);
        lookup(20'h88880, 10'd0);
        expect_miss("sweep_write_ignored");

        // illegal op: immediate done, nothing changes
        bus.inv_req = 1'b1; bus.inv_op = 5'd7;
        tick();
        bus.inv_req = 1'b0;
        chk("op7_done", 89'(bus.inv_done), 89'(1));
        chk("op7_busy", 89'(bus.inv_busy), 89'(0));
        tick();
        chk("op7_done_pulse", 89'(bus.inv_done), 89'(0));
        lookup(20'h22220, 10'd0);
        expect_hit("op7_kept", 4'd2, 20'h22222);

        // op 5: g=0, asid 6, VA match clears entry 5 only
        run_inv(5'd5, 10'd6, 20'h0AAAB);
        lookup(20'h0AAAB, 10'd6);
        expect_miss("op5_cleared5");
        lookup(20'h22220, 10'd0);
        expect_hit("op5_kept2", 4'd2, 20'h22222);

        // op 6: global entry with VA match cleared, entry 7 (same VA) too
        run_inv(5'd6, 10'd0, 20'h22220);
        lookup(20'h22220, 10'd0);
        expect_miss("op6_cleared");
        lookup(20'h80055, 10'd0);
        expect_hit("op6_kept0", 4'd0, 20'h00255);

        // reset during an op-0 sweep
        bus.inv_req = 1'b1; bus.inv_op = 5'd0;
        tick();
        bus.inv_req = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", 89'(bus.inv_busy), 89'(1));
        resetn = 1'b0;
        #2;
        chk("midrst_busy",  89'(bus.inv_busy), 89'(0));
        chk("midrst_ready", 89'(bus.s_ready),  89'(1));
        resetn = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.inv_done) done_seen = 1'b1;
        end
        chk("midrst_no_done", 89'(done_seen), 89'(0));
        lookup(20'h80055, 10'd0);
        expect_miss("midrst_miss0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlb_lookup.md
# tlb_lookup

Fully-associative TLB that answers translation lookups from the fetch/memory-stage address translator, which raises a lookup for every address not covered by direct-mapped windows and consumes the returned PFN/MAT. Also services TLBWR/TLBFILL writes, TLBRD reads and a multi-cycle INVTLB sweep. Lookups and reads complete in one registered cycle; invalidation walks one entry per cycle.

## Interface
- TLBNUM, 16, entry count (power of two, 4..64); IDXW = log2(TLBNUM)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- s_req  in  1  lookup request; accepted when s_ready=1
- s_ready  out  1  = ~inv_busy
- s_vpn  in  20  VA[31:12]
- s_asid  in  10  current ASID
- s_valid  out  1  lookup response pulse
- s_hit  out  1  matching entry found
- s_index  out  IDXW  index of hit entry
- s_pfn  out  20  physical frame number
- s_mat, s_plv  out  2 each  page MAT / PLV
- s_d, s_v  out  1 each  page dirty / valid
- w_en  in  1  write entry
- w_index  in  IDXW  write target
- w_entry  in  89  packed {vppn[18:0], ps[5:0], g, asid[9:0], e, ppn0[19:0], plv0, mat0, d0, v0, ppn1[19:0], plv1, mat1, d1, v1}
- r_en  in  1  read request
- r_index  in  IDXW  read target
- r_valid  out  1  read response pulse
- r_entry  out  89  entry contents, same packing
- inv_req  in  1  start INVTLB; accepted when inv_busy=0
- inv_op  in  5  INVTLB op code
- inv_asid  in  10  ASID operand
- inv_vpn  in  20  VA[31:12] operand
- inv_busy  out  1  sweep in progress
- inv_done  out  1  one-cycle completion pulse

## Operation
- Entry match: e=1 AND (g=1 OR asid==s_asid) AND (ps==12 ? vppn==s_vpn[19:1] : vppn[18:9]==s_vpn[19:10]). Only ps 12 and 21 are legal; other ps never match.
- Odd-page select: ps==12 -> s_vpn[0]; ps==21 -> s_vpn[9]. Selects page 1 when set, else page 0.
- s_pfn: ps==12 -> ppnX; ps==21 -> {ppnX[19:9], s_vpn[8:0]}.
- Multiple hits: lowest index wins. Miss: s_hit=0, s_index/s_pfn/s_mat/s_plv/s_d/s_v=0.
- Write: entry[w_index] <= w_entry on the edge. Ignored while inv_busy=1.
- Read: r_entry <= entry[r_index]; honoured during sweep (shows current contents).
- FSM: IDLE -> (inv_req & legal op) SWEEP -> DONE -> IDLE. Illegal op (>6): IDLE -> DONE directly, no entry modified.
- SWEEP: counter idx from 0 to TLBNUM-1, one entry per cycle; clears e of entry[idx] when predicate holds:
  - op 0,1: all; op 2: g=1; op 3: g=0; op 4: g=0 & asid==inv_asid;
  - op 5: g=0 & asid==inv_asid & VA match; op 6: (g=1 | asid==inv_asid) & VA match; VA match uses the ps rule above with inv_vpn.
- Operands latched at inv_req acceptance; later changes have no effect.

## Timing
- Reset: every entry e=0 and all fields 0; FSM IDLE, idx=0; all outputs 0 except s_ready=1.
- Lookup latency 1: s_req accepted at edge N -> s_valid=1 with results during cycle N+1; back-to-back one per cycle.
- Lookup and write same cycle: lookup sees pre-write contents; following cycle sees new entry.
- Read latency 1, same rules as lookup.
- INVTLB legal op: inv_busy=1 for TLBNUM cycles after acceptance, then inv_done=1 for 1 cycle (inv_busy=0 in that cycle); total TLBNUM+1 cycles. Illegal op: inv_done 1 cycle after acceptance, inv_busy never rises.
- s_req with s_ready=0 is dropped; no s_valid.
- inv_req while busy is ignored.
- resetn low mid-sweep: immediate return to IDLE, all entries invalid, no inv_done.

## Test plan
- Reset then lookup s_vpn=0x12345 -> s_valid next cycle, s_hit=0, s_pfn=0.
- Write idx 3 {vppn=0x091A2, ps=12, g=0, asid=5, e=1, ppn1=0xABCDE, mat1=1, v1=1}; lookup s_vpn=0x12345, asid=5 -> s_hit=1, s_index=3, s_pfn=0xABCDE, s_mat=1, s_v=1; asid=6 -> miss.
- 2MB entry idx 0 {vppn=0x40000, ps=21, g=1, ppn0=0x00200, v0=1}; lookup s_vpn=0x80055 -> hit, s_pfn=0x00255; s_vpn=0x80255 -> selects page 1.
- Same VA at idx 2 and idx 7 -> s_index=2.
- INVTLB op 4 asid=5 with TLBNUM=16: inv_busy 16 cycles, s_ready=0 and s_req dropped, inv_done on cycle 17; g=0/asid=5 entries miss, g=1 entries still hit.
- inv_op=7 -> inv_done next cycle, no busy, entries unchanged; resetn pulse mid op-0 sweep -> all miss, no inv_done.
